tap_accumulator: RTL and testbench

Sequential multiply-accumulate back end for the adaptive FIR path of the ANC datapath. It sits directly downstream of the 11x11 sign-magnitude multiplier and consumes one 21-bit sign-magnitude product per valid cycle. It sums NUM_TAPS products in a two's-complement accumulator, then rescales and saturates the sum. The result is one 11-bit sign-magnitude filter output sample, the same format as the multiplier operands, so it can feed back into the filter or the error path.

---
 rtl/tap_accumulator.sv | 96 +++++++++
 tb/tb_tap_accumulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tap_accumulator.sv
// Sequential MAC back end for the adaptive FIR path.
// Sums NUM_TAPS sign-magnitude products, then rescales and saturates.
module tap_accumulator #(
  parameter int NUM_TAPS  = 16,
  parameter int ACC_W     = 26,
  parameter int OUT_SHIFT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        prod_valid,
  input  logic [20:0] prod_in,
  output logic        busy,
  output logic        acc_valid,
  output logic [10:0] acc_out,
  output logic        sat
);

  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] prod_ext;
  logic             acc_neg;
  logic [ACC_W-1:0] abs_acc;
  logic [ACC_W-1:0] shifted;
  logic             sat_next;
  logic [9:0]       mag_next;
  logic             sign_next;

  // Product to two's complement, and accumulator to saturated sign-magnitude
  always_comb begin
    mag_ext   = ACC_W'(prod_in[19:0]);
    prod_ext  = prod_in[20] ? (~mag_ext + ACC_W'(1)) : mag_ext;
    acc_neg   = acc[ACC_W-1];
    abs_acc   = acc_neg ? (~acc + ACC_W'(1)) : acc;
    shifted   = abs_acc >> OUT_SHIFT;
    sat_next  = shifted > ACC_W'(1023);
    mag_next  = sat_next ? 10'h3FF : shifted[9:0];
    sign_next = acc_neg && (mag_next != 10'd0);
  end

  // Control FSM with accumulator and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      acc_valid <= 1'b0;
      acc_out   <= '0;
      sat       <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc   <= acc + prod_ext;
            count <= count + CNT_W'(1);
            if (count == LAST) state <= DONE;
          end
        end
        DONE: begin
          acc_out   <= {sign_next, mag_next};
          sat       <= sat_next;
          acc_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_accumulator.sv
// Scoreboard bench for tap_accumulator.
// Stimulus pushes expected results; a negedge monitor checks them.
module tb_tap_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        prod_valid;
  logic [20:0] prod_in;
  logic        busy;
  logic        acc_valid;
  logic [10:0] acc_out;
  logic        sat;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [10:0] out;
    logic        s;
    int          due;
  } exp_t;

  exp_t q[$];
  logic prev_v = 1'b0;
  int   s1;
  int   s2;

  tap_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .busy       (busy),
    .acc_valid  (acc_valid),
    .acc_out    (acc_out),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every acc_valid
  always @(negedge clk) begin
    exp_t e;
    if (acc_valid) begin
      chk("acc_valid_single", int'(prev_v), 0);
      chk("busy_at_valid", int'(busy), 0);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got acc_out 0x%0h, want no result",
                 acc_out);
      end else begin
        e = q.pop_front();
        chk("acc_out", int'(acc_out), int'(e.out));
        chk("sat", int'(sat), int'(e.s));
        chk("latency", cyc, e.due);
      end
    end
    prev_v <= acc_valid;
  end

  task automatic step(input logic st, input logic pv, input logic [20:0] p);
    start      = st;
    prod_valid = pv;
    prod_in    = p;
    @(posedge clk);
    #1;
  endtask

  // start, then 16 products; optional gap after tap gi, start pulse at tap si
  task automatic run(input logic [20:0] p0, input logic [20:0] p1,
                     input int gi, input int glen, input int si,
                     input logic [10:0] eo, input logic es);
    exp_t e;
    step(1'b1, 1'b0, 21'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        e.out = eo;
        e.s   = es;
        e.due = cyc + 2;
        q.push_back(e);
      end
      step(i == si, 1'b1, (i < 8) ? p0 : p1);
      if (i == gi) begin
        for (int g = 0; g < glen; g++) begin
          step(1'b0, 1'b0, 21'h1FFFFF);
          chk("busy_in_gap", int'(busy), 1);
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    prod_valid = 1'b0;
    prod_in    = '0;
    step(1'b1, 1'b1, 21'h00400);
    step(1'b1, 1'b1, 21'h00400);
    chk("rst_busy", int'(busy), 0);
    chk("rst_acc_valid", int'(acc_valid), 0);
    chk("rst_acc_out", int'(acc_out), 0);
    chk("rst_sat", int'(sat), 0);
    rst = 1'b0;
    step(1'b0, 1'b1, 21'h00400);
    chk("idle_busy", int'(busy), 0);

    // 16 x +1024 -> +16; then back-to-back 16 x -64512 -> -1008
    s1 = cyc;
    run(21'h00400, 21'h00400, -1, 0, -1, 11'h010, 1'b0);
    step(1'b0, 1'b0, 21'h0);
    s2 = cyc;
    chk("period", s2 - s1, 18);
    run(21'h10FC00, 21'h10FC00, -1, 0, -1, 11'h7F0, 1'b0);
    step(1'b0, 1'b0, 21'h0);

    // 16 x -1024 with a 3-cycle gap after the 5th tap -> -16
    run(21'h100400, 21'h100400, 4, 3, -1, 11'h410, 1'b0);
    step(1'b0, 1'b0, 21'h0);

    // cancelling sum with ignored start -> zero, no negative zero
    run(21'h00800, 21'h100800, -1, 0, 4, 11'h000, 1'b0);
    step(1'b0, 1'b0, 21'h0);

    // -1600 truncates toward zero to -1
    run(21'h100064, 21'h100064, -1, 0, -1, 11'h401, 1'b0);
    step(1'b0, 1'b0, 21'h0);

    // negative-zero product contributes nothing
    run(21'h100000, 21'h00400, -1, 0, -1, 11'h008, 1'b0);
    step(1'b0, 1'b0, 21'h0);

    // saturation both signs
    run(21'h40000, 21'h40000, -1, 0, -1, 11'h3FF, 1'b1);
    step(1'b0, 1'b0, 21'h0);
    run(21'h140000, 21'h140000, -1, 0, -1, 11'h7FF, 1'b1);
    step(1'b0, 1'b0, 21'h0);
    step(1'b0, 1'b0, 21'h0);

    // reset mid-accumulation discards the partial sum
    step(1'b1, 1'b0, 21'h0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 21'h00400);
    chk("busy_mid", int'(busy), 1);
    rst = 1'b1;
    step(1'b0, 1'b1, 21'h00400);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(acc_valid), 0);
    chk("mid_rst_out", int'(acc_out), 0);
    chk("mid_rst_sat", int'(sat), 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 21'h00400);
    run(21'h00400, 21'h00400, -1, 0, -1, 11'h010, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 1'b0, 21'h0);
    step(1'b0, 1'b0, 21'h0);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
